// File: rtl/image_row_streamer.sv
// Image row buffer + word serialiser feeding the DCNN input, followed by a CNN-data pass-through phase.
// Optional: define IMG_STREAMER_MSB_FIRST_EN to emit each row's words MSB-first instead of LSB-first.
module image_row_streamer #(
  parameter int ROW_WIDTH  = 480,
  parameter int WORD_WIDTH = 16,
  parameter int NUM_ROWS   = 29,
  parameter int ROW_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROW_WIDTH-1:0]  row_in,
  input  logic                  send,
  input  logic                  stop,
  input  logic [WORD_WIDTH-1:0] cnn_data_in,
  input  logic                  cnn_valid_in,
  input  logic                  cnn_last_in,
  output logic                  cnn_ready_out,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_row_end,
  output logic                  cnn_image,
  output logic                  load_process,
  output logic                  send_drop,
  output logic [7:0]            row_count
);

  localparam int WPR = ROW_WIDTH / WORD_WIDTH;
  localparam int WCW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PW  = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
  localparam int CW  = $clog2(ROW_DEPTH + 1);

  typedef enum logic [1:0] {IMAGE, DRAIN, CNN, DONE} phase_t;

  typedef struct packed {
    logic                  row_end;
    logic [WORD_WIDTH-1:0] data;
  } word_t;

  phase_t                 phase, phase_nxt;
  logic                   send_q;
  logic [ROW_WIDTH-1:0]   row_buf [ROW_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr, src;
  logic [CW-1:0]          count, count_eff;
  logic [WCW-1:0]         wcnt;
  word_t                  out_q;
  logic                   valid_q;

  logic                   img, send_edge, try_send, full, accept, drop;
  logic                   load_en, pend, free, avail, load_img, cnn_take;
  logic [WPR-1:0][WORD_WIDTH-1:0] head_words;
  logic [WORD_WIDTH-1:0]  head_word;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(ROW_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_data    = out_q.data;
  assign out_row_end = out_q.row_end;
  assign out_valid   = valid_q;

  assign img       = (phase == IMAGE) || (phase == DRAIN);
  assign send_edge = send & ~send_q;
  assign load_en   = ~valid_q | out_ready;

  // The head entry stays occupied until its last word leaves the output register,
  // so while that word sits there the serialiser already reads from the next entry.
  assign pend      = valid_q & out_q.row_end;
  assign free      = img & valid_q & out_ready & out_q.row_end;
  assign src       = pend ? next_ptr(rd_ptr) : rd_ptr;
  assign avail     = pend ? (count > CW'(1)) : (count != '0);
  assign load_img  = img & load_en & avail;

  // Free is applied before the full test, so a same-cycle free makes room.
  assign count_eff = count - CW'(free);
  assign full      = (count_eff == CW'(ROW_DEPTH));
  assign try_send  = send_edge & ~stop & (phase == IMAGE);
  assign accept    = try_send & ~full;
  assign drop      = try_send & full;

  assign cnn_ready_out = cnn_image & load_en;
  assign cnn_take      = cnn_ready_out & cnn_valid_in;

  assign head_words = row_buf[src];
`ifdef IMG_STREAMER_MSB_FIRST_EN
  assign head_word = head_words[WCW'(WPR - 1) - wcnt];
`else
  assign head_word = head_words[wcnt];
`endif

  always_comb begin
    phase_nxt    = phase;
    cnn_image    = 1'b0;
    load_process = 1'b1;
    unique case (phase)
      IMAGE: if (accept && row_count == 8'(NUM_ROWS - 1)) phase_nxt = DRAIN;
      DRAIN: if (free && count == CW'(1)) phase_nxt = CNN;
      CNN: begin
        cnn_image = 1'b1;
        if (cnn_take && cnn_last_in) phase_nxt = DONE;
      end
      default: begin
        cnn_image    = 1'b1;
        load_process = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase     <= IMAGE;
      send_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wcnt      <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      send_drop <= 1'b0;
      row_count <= '0;
    end else begin
      phase     <= phase_nxt;
      send_q    <= send;
      send_drop <= drop;
      count     <= count_eff + CW'(accept);
      row_count <= row_count + 8'(accept);
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (free)   rd_ptr <= next_ptr(rd_ptr);
      if (load_img) begin
        out_q.data    <= head_word;
        out_q.row_end <= (wcnt == WCW'(WPR - 1));
        valid_q       <= 1'b1;
        wcnt          <= (wcnt == WCW'(WPR - 1)) ? '0 : wcnt + WCW'(1);
      end else if (cnn_take) begin
        out_q.data    <= cnn_data_in;
        out_q.row_end <= 1'b0;
        valid_q       <= 1'b1;
      end else if (load_en) begin
        out_q.row_end <= 1'b0;
        valid_q       <= 1'b0;
      end
    end
  end

  // Row storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) row_buf[wr_ptr] <= row_in;
  end

endmodule

// File: tb/tb_image_row_streamer.sv
// Directed bench for image_row_streamer: latency, backpressure/drop, stop, full load, CNN pass-through, mid-load reset.
module tb_image_row_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic [479:0] row_in;
  logic         send, stop;
  logic [15:0]  cnn_data_in;
  logic         cnn_valid_in, cnn_last_in, cnn_ready_out;
  logic [15:0]  out_data;
  logic         out_valid, out_ready, out_row_end;
  logic         cnn_image, load_process, send_drop;
  logic [7:0]   row_count;

  int          checks = 0;
  int          errors = 0;
  int          words  = 0;
  logic        cnn_acc;
  logic        lp_before;
  logic [16:0] exp_q [$];
  int          idx;

  image_row_streamer dut (
    .clk(clk), .rst(rst), .row_in(row_in), .send(send), .stop(stop),
    .cnn_data_in(cnn_data_in), .cnn_valid_in(cnn_valid_in), .cnn_last_in(cnn_last_in),
    .cnn_ready_out(cnn_ready_out), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row_end(out_row_end), .cnn_image(cnn_image),
    .load_process(load_process), .send_drop(send_drop), .row_count(row_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [479:0] mk_row(input int r);
    logic [29:0][15:0] w;
    for (int i = 0; i < 30; i++) w[i[4:0]] = {r[7:0], i[7:0]};
    return w;
  endfunction

  task automatic push_row(input int r);
    for (int i = 0; i < 30; i++) exp_q.push_back({(i == 29), r[7:0], i[7:0]});
  endtask

  // Score every output handshake and note CNN-side acceptance, then advance one clock.
  task automatic step();
    logic [16:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_word", {15'd0, out_row_end, out_data}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("word", {15'd0, out_row_end, out_data}, {15'd0, e});
        words++;
      end
    end
    cnn_acc = cnn_ready_out & cnn_valid_in;
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int r);
    row_in = mk_row(r);
    push_row(r);
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (29) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) step();
  endtask

  initial begin
    rst = 1'b0; row_in = '0; send = 1'b0; stop = 1'b0;
    cnn_data_in = '0; cnn_valid_in = 1'b0; cnn_last_in = 1'b0; out_ready = 1'b1;
    cnn_acc = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_row_end", out_row_end, 0);
    chk("rst_cnn_image", cnn_image, 0);
    chk("rst_load_process", load_process, 1);
    chk("rst_send_drop", send_drop, 0);
    chk("rst_row_count", row_count, 0);
    chk("rst_cnn_ready", cnn_ready_out, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Row 1: word0=0002, word1=0001, rest zero; one-cycle latency then 30 words.
    row_in = '0;
    row_in[31:0] = 32'h0001_0002;
    for (int i = 0; i < 30; i++)
      exp_q.push_back({(i == 29), (i == 0) ? 16'h0002 : (i == 1) ? 16'h0001 : 16'h0000});
    send = 1'b1;
    step();
    chk("r1_row_count", row_count, 1);
    chk("r1_no_early_valid", out_valid, 0);
    send = 1'b0;
    step();
    chk("r1_w0_valid", out_valid, 1);
    chk("r1_w0_data", out_data, 16'h0002);
    repeat (30) step();
    chk("r1_idle_after", out_valid, 0);
    chk("r1_all_words", exp_q.size(), 0);

    // Backpressure: 3 edges with out_ready low, third is dropped.
    out_ready = 1'b0;
    row_in = mk_row(2); push_row(2); send = 1'b1; step();
    send = 1'b0; step();
    chk("stall_w0", out_data, 16'h0200);
    row_in = mk_row(3); push_row(3); send = 1'b1; step();
    chk("stall_row_count3", row_count, 3);
    send = 1'b0; step();
    row_in = mk_row(99); send = 1'b1; step();
    chk("drop_pulse", send_drop, 1);
    chk("drop_row_count", row_count, 3);
    send = 1'b0; step();
    chk("drop_pulse_end", send_drop, 0);
    chk("stall_hold_data", out_data, 16'h0200);
    chk("stall_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (60) step();
    chk("b2b_idle_after", out_valid, 0);
    chk("b2b_all_words", exp_q.size(), 0);

    // stop=1 masks an edge entirely.
    stop = 1'b1; row_in = mk_row(98); send = 1'b1; step();
    chk("stop_row_count", row_count, 3);
    chk("stop_no_drop", send_drop, 0);
    stop = 1'b0; send = 1'b0; step();
    chk("stop_no_capture", out_valid, 0);

    // Remaining rows complete the load, then the CNN phase starts.
    for (int r = 4; r <= 29; r++) send_row(r);
    chk("full_row_count", row_count, 29);
    chk("still_image", cnn_image, 0);
    drain();
    chk("img_words", words, 870);
    chk("cnn_image_rise", cnn_image, 1);
    chk("cnn_ready_first", cnn_ready_out, 1);
    chk("cnn_no_row_end", out_row_end, 0);
    row_in = mk_row(97); send = 1'b1; step();
    chk("late_edge_count", row_count, 29);
    chk("late_edge_no_drop", send_drop, 0);
    send = 1'b0;

    // CNN pass-through with out_ready toggling.
    idx = 0;
    for (int c = 0; c < 60 && (idx < 4 || exp_q.size() > 0); c++) begin
      out_ready    = (c % 3 != 1);
      cnn_valid_in = (idx < 4);
      cnn_data_in  = 16'hA001 + 16'(idx);
      cnn_last_in  = (idx == 3);
      lp_before    = load_process;
      step();
      if (cnn_acc) begin
        exp_q.push_back({1'b0, 16'hA001 + 16'(idx)});
        if (idx == 3) begin
          chk("lp_before_last", lp_before, 1);
          chk("lp_after_last", load_process, 0);
        end
        idx++;
      end
    end
    cnn_valid_in = 1'b0; cnn_last_in = 1'b0; out_ready = 1'b1;
    chk("cnn_words_in", idx, 4);
    chk("cnn_words_out", exp_q.size(), 0);
    chk("done_load_process", load_process, 0);
    chk("done_cnn_image", cnn_image, 1);

    // Fresh load aborted by reset midway through row 5.
    rst = 1'b0; #2 rst = 1'b1;
    step();
    for (int r = 1; r <= 4; r++) send_row(r);
    row_in = mk_row(5); push_row(5); send = 1'b1; step();
    send = 1'b0;
    repeat (10) step();
    chk("pre_abort_count", row_count, 5);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_row_end", out_row_end, 0);
    chk("abort_row_count", row_count, 0);
    chk("abort_load_process", load_process, 1);
    chk("abort_cnn_image", cnn_image, 0);
    chk("abort_cnn_ready", cnn_ready_out, 0);
    exp_q.delete();
    #2 rst = 1'b1;
    step();
    chk("restart_idle", out_valid, 0);
    row_in = mk_row(7); push_row(7); send = 1'b1; step();
    chk("restart_row_count", row_count, 1);
    send = 1'b0;
    repeat (29) step();
    drain();
    chk("restart_all_words", exp_q.size(), 0);
    chk("restart_idle_after", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
